// File: rtl/vliw_stage_reg.sv
// Multi-lane VLIW pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, global flush, per-lane kill and a saturating stall counter.
module vliw_stage_reg #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 40,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       in_nop,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       lane_kill,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_nop,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int unsigned DW = LANES * WIDTH;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [LANES-1:0] main_nop_q, main_nop_d;
  logic [LANES-1:0] skid_nop_q, skid_nop_d;
  logic [DW-1:0]    main_data_q, main_data_d;
  logic [DW-1:0]    skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             in_fire;
  logic             out_fire;
  logic [LANES-1:0] acc_nop;

  assign out_valid = (state_q != StEmpty);
  assign out_nop   = main_nop_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

  // Without a skid entry, a full main register can only accept when it drains this cycle.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign acc_nop  = in_nop | lane_kill;

  always_comb begin
    state_d     = state_q;
    main_nop_d  = main_nop_q;
    main_data_d = main_data_q;
    skid_nop_d  = skid_nop_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d    = StEmpty;
      main_nop_d = '1;
      skid_nop_d = '1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_nop_d  = acc_nop;
            main_data_d = in_data;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (out_fire && in_fire) begin
            main_nop_d  = acc_nop;
            main_data_d = in_data;
          end else if (out_fire) begin
            main_nop_d = '1;
            state_d    = StEmpty;
          end else if (in_fire) begin
            skid_nop_d  = acc_nop;
            skid_data_d = in_data;
            state_d     = StFull;
          end
        end
        StFull: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (out_fire) begin
            main_nop_d  = skid_nop_q;
            main_data_d = skid_data_q;
            skid_nop_d  = '1;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    in_ready_d = (state_d != StFull);

    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StEmpty;
      main_nop_q  <= '1;
      main_data_q <= '0;
      skid_nop_q  <= '1;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_nop_q  <= main_nop_d;
      main_data_q <= main_data_d;
      skid_nop_q  <= skid_nop_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_vliw_stage_reg.sv
// Self-checking bench for vliw_stage_reg (LANES=4, WIDTH=40, SKID=1, CNT_W=4)
// using a queue that mirrors the bundles held in the stage.
module tb_vliw_stage_reg;

  localparam int unsigned LANES = 4;
  localparam int unsigned WIDTH = 40;
  localparam int unsigned DW    = LANES * WIDTH;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LANES-1:0] in_nop = '0;
  logic [DW-1:0]    in_data = '0;
  logic [LANES-1:0] lane_kill = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LANES-1:0] out_nop;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct packed {
    logic [LANES-1:0] nop;
    logic [DW-1:0]    data;
  } ent_t;

  ent_t             sb[$];    // bundles held by the stage, head drives out_*
  ent_t             pend[$];  // bundles still to be offered upstream
  logic             rdy_m = 1'b1;
  logic [CNT_W-1:0] stall_m = '0;
  bit               nop_known = 1'b1;
  int               n_chk = 0;
  int               n_fail = 0;

  vliw_stage_reg #(
    .LANES(LANES),
    .WIDTH(WIDTH),
    .SKID (1),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_nop   (in_nop),
    .in_data  (in_data),
    .lane_kill(lane_kill),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_nop  (out_nop),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", DW'(out_valid), DW'(sb.size() > 0));
    check_eq("in_ready", DW'(in_ready), DW'(rdy_m));
    check_eq("stall_cnt", DW'(stall_cnt), DW'(stall_m));
    if (sb.size() > 0) begin
      check_eq("out_data", out_data, sb[0].data);
      check_eq("out_nop", DW'(out_nop), DW'(sb[0].nop));
    end else if (nop_known) begin
      check_eq("out_nop_idle", DW'(out_nop), DW'(4'hF));
    end
  endtask

  // Called at a falling edge with inputs driven: check, advance model, cross one cycle.
  task automatic step();
    bit   fire_in;
    bit   fire_out;
    ent_t e;
    check_outputs();
    fire_in  = in_valid && rdy_m;
    fire_out = (sb.size() > 0) && out_ready;
    if ((sb.size() > 0) && !out_ready && (stall_m != 4'hF)) stall_m = stall_m + 4'd1;
    if (flush) begin
      sb.delete();
      nop_known = 1'b1;
    end else begin
      if (fire_out) void'(sb.pop_front());
      if (fire_in) begin
        e.nop  = in_nop | lane_kill;
        e.data = in_data;
        sb.push_back(e);
        nop_known = 1'b0;
        if (pend.size() > 0 && pend[0].data == in_data) void'(pend.pop_front());
      end
    end
    rdy_m = flush || (sb.size() < 2);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer();
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      in_nop   = pend[0].nop;
      in_data  = pend[0].data;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic queue_bundle(input logic [LANES-1:0] nop, input logic [DW-1:0] data);
    ent_t e;
    e.nop  = nop;
    e.data = data;
    pend.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (pend.size() > 0 || sb.size() > 0); i++) begin
      offer();
      step();
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_nop    = 4'($urandom);
      in_data   = rand_data();
      lane_kill = 4'($urandom);
      flush     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("rst_out_valid", DW'(out_valid), DW'(1'b0));
      check_eq("rst_out_nop", DW'(out_nop), DW'(4'hF));
      check_eq("rst_out_data", out_data, '0);
      check_eq("rst_in_ready", DW'(in_ready), DW'(1'b1));
      check_eq("rst_stall_cnt", DW'(stall_cnt), '0);
    end
    in_valid = 1'b0; lane_kill = '0; flush = 1'b0; out_ready = 1'b0; in_nop = '0;
    rst = 1'b1;

    // First bundle after release
    in_valid = 1'b1; in_data = DW'(160'hA5A5); in_nop = 4'b0010;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    step();

    // Streaming: 10 back-to-back bundles, data = k
    for (int k = 0; k < 10; k++) queue_bundle(4'b0000, DW'(k));
    drain(30);

    // Backpressure: A, B, C with out_ready low for four cycles
    queue_bundle(4'b0000, DW'(160'hA)); queue_bundle(4'b0001, DW'(160'hB));
    queue_bundle(4'b0010, DW'(160'hC));
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin offer(); step(); end
    out_ready = 1'b1;
    drain(20);

    // Flush in FULL with a bundle offered
    out_ready = 1'b0;
    queue_bundle(4'b0000, DW'(160'h11)); queue_bundle(4'b0000, DW'(160'h22));
    for (int i = 0; i < 3; i++) begin offer(); step(); end
    flush = 1'b1; in_valid = 1'b1; in_data = DW'(160'hDEAD); in_nop = '0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    step();

    // Lane kill on accepted bundle; held bundle ignores later kill
    in_valid = 1'b1; in_nop = 4'b0000; lane_kill = 4'b0101; in_data = rand_data();
    step();
    in_valid = 1'b0; lane_kill = 4'b1111;
    step();
    step();
    lane_kill = '0; out_ready = 1'b1;
    step();
    step();

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_nop    = 4'($urandom);
      in_data   = rand_data();
      lane_kill = 4'($urandom);
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0; lane_kill = '0;

    // Asynchronous reset mid-operation with bundles held
    out_ready = 1'b0; in_valid = 1'b1; in_nop = '0;
    for (int i = 0; i < 3; i++) begin in_data = rand_data(); step(); end
    rst = 1'b0;
    #1;
    check_eq("arst_out_valid", DW'(out_valid), DW'(1'b0));
    check_eq("arst_out_nop", DW'(out_nop), DW'(4'hF));
    check_eq("arst_out_data", out_data, '0);
    check_eq("arst_in_ready", DW'(in_ready), DW'(1'b1));
    check_eq("arst_stall_cnt", DW'(stall_cnt), '0);
    sb.delete(); pend.delete();
    rdy_m = 1'b1; stall_m = '0; nop_known = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    // Saturation: held bundle, out_ready low for 20 cycles
    in_valid = 1'b1; in_data = DW'(160'h5A); in_nop = '0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("stall_sat", DW'(stall_cnt), DW'(4'hF));
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check_eq("stall_after_flush", DW'(stall_cnt), DW'(4'hF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/vliw_stage_reg.md
# vliw_stage_reg

Parametrised, multi-lane pipeline stage register for the VLIW issue path. It is the general successor to the per-unit ID/EX registers. One instance carries a whole instruction bundle (LANES slots of WIDTH-bit decoded payload) between two pipeline stages. It adds a valid/ready handshake, an optional 2-entry skid buffer, a global flush and per-lane kill, and a backpressure stall counter.

## Interface
Parameters:
- LANES, 4: number of issue slots per bundle (≥1)
- WIDTH, 40: decoded payload bits per lane (≥1)
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CNT_W, 16: stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- in_valid  in  1  upstream bundle present
- in_ready  out  1  stage can accept a bundle this cycle
- in_nop  in  LANES  per-lane nop flag of incoming bundle
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- lane_kill  in  LANES  force lane i of the accepted incoming bundle to nop
- flush  in  1  synchronous squash of all held and incoming bundles
- out_valid  out  1  bundle held for downstream
- out_ready  in  1  downstream accepts
- out_nop  out  LANES  per-lane nop flag of held bundle
- out_data  out  LANES*WIDTH  held payload
- stall_cnt  out  CNT_W  saturating count of backpressured cycles

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Accepted lane nop = in_nop[i] | lane_kill[i]. Payload is stored unmodified, including for nop lanes.
- State (SKID=1): main entry (drives outputs) and skid entry, each holding valid, nop[LANES] and data.
- States: EMPTY (main invalid), ONE (main valid, skid invalid), FULL (both valid).
- EMPTY: in_fire loads main, giving ONE.
- ONE with out_fire and in_fire: main reloads, state stays ONE. With out_fire only: EMPTY. With in_fire only: load skid, giving FULL.
- FULL with out_fire: skid moves to main, giving ONE. FULL without out_fire: hold.
- in_ready (SKID=1) = registered !FULL. It deasserts the cycle after entering FULL and reasserts the cycle after leaving it. In_fire never occurs in FULL.
- SKID=0: main entry only. in_ready = !out_valid | out_ready (combinational). The main entry loads on in_fire and clears on out_fire without in_fire.
- flush takes priority over every transfer. Next edge: main and skid are invalid, nop = all 1, and data is held (don't care). A bundle offered in the flush cycle is dropped, even if in_ready=1. out_fire in the flush cycle still counts as delivered downstream.
- lane_kill affects only the bundle accepted in the same cycle. Held entries are never modified by lane_kill.
- stall_cnt increments when out_valid & !out_ready, saturates at 2^CNT_W−1, and is unaffected by flush.
- Bundle order is strictly preserved. No bundle is duplicated or lost except by flush.

## Timing
- Reset values: out_valid=0, out_nop=all 1, out_data=0, skid cleared (invalid, nop=1, data=0), in_ready=1, stall_cnt=0.
- Reset assertion takes effect immediately (asynchronous). After release, the first edge may accept.
- Latency is 1 cycle: a bundle accepted at edge N appears on out_* after edge N and is valid in cycle N+1.
- Throughput is 1 bundle/cycle while out_ready=1, for both SKID settings.
- SKID=1: in_ready has no combinational path from out_ready. Up to 2 bundles are absorbed after out_ready falls.
- Reset mid-operation: all held bundles are discarded, with no partial outputs.

## Test plan
- Reset: hold rst=0 and drive random inputs. Require out_valid=0, out_nop=4'b1111, out_data=0, in_ready=1, stall_cnt=0. Release, drive one bundle, and require it on out_* the next cycle.
- Streaming: out_ready=1, 10 back-to-back bundles with data=k. Require out_data=k on cycle k+1, out_valid continuous, in_ready constant 1.
- Backpressure (SKID=1): drop out_ready while streaming A,B,C. Require A held, B captured into skid, in_ready=0 the following cycle, C held off upstream. Raise out_ready; require A,B,C delivered in order, stall_cnt = number of low-ready cycles.
- Flush in FULL state with in_valid=1: next cycle require out_valid=0, out_nop=all 1, in_ready=1, offered bundle absent from output.
- lane_kill=4'b0101 with in_nop=0: require out_nop=4'b0101 and data lanes 0/2 unchanged. A held bundle during lane_kill keeps its nop bits.
- Saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles. Require stall_cnt=15 and holding, with no wrap to 0.
